// File: rtl/regfile_mp.sv
// Multi-port register file with optional write-to-read bypass and a per-register
// busy scoreboard (reserve at issue, clear at writeback, bulk flush).
module regfile_mp #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 32,
   parameter int ABITS    = $clog2(DEPTH),
   parameter int NRD      = 2,
   parameter int NWR      = 2,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic                 clk,
   input  logic                 nrst,
   input  logic [NRD*ABITS-1:0] rd_addr,
   output logic [NRD*WIDTH-1:0] rd_data,
   output logic [NRD-1:0]       rd_busy,
   input  logic [NWR-1:0]       wr_en,
   input  logic [NWR*ABITS-1:0] wr_addr,
   input  logic [NWR*WIDTH-1:0] wr_data,
   input  logic                 rsv_en,
   input  logic [ABITS-1:0]     rsv_addr,
   input  logic                 flush
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0] busy;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         localparam logic [ABITS-1:0] IDX = ABITS'(gi);

         if (ZERO_REG && gi == 0) begin : g_zero
            assign mem[gi]  = '0;
            assign busy[gi] = 1'b0;
         end else begin : g_reg
            logic [WIDTH-1:0] data_reg;
            logic             busy_reg;
            logic             wr_hit;
            logic [WIDTH-1:0] wr_val;
            logic             busy_next;

            // Later ports overwrite earlier matches so the highest index wins.
            always_comb begin
               wr_hit = 1'b0;
               wr_val = '0;
               for (int j = 0; j < NWR; j++) begin
                  if (wr_en[j] && wr_addr[j*ABITS +: ABITS] == IDX) begin
                     wr_hit = 1'b1;
                     wr_val = wr_data[j*WIDTH +: WIDTH];
                  end
               end
            end

            // A new reservation supersedes a same-cycle writeback from the old producer.
            always_comb begin
               busy_next = busy_reg;
               if (flush) begin
                  busy_next = 1'b0;
               end else if (rsv_en && rsv_addr == IDX) begin
                  busy_next = 1'b1;
               end else if (wr_hit) begin
                  busy_next = 1'b0;
               end
            end

            always_ff @(posedge clk or negedge nrst) begin
               if (!nrst) begin
                  data_reg <= '0;
                  busy_reg <= 1'b0;
               end else begin
                  if (wr_hit) begin
                     data_reg <= wr_val;
                  end
                  busy_reg <= busy_next;
               end
            end

            assign mem[gi]  = data_reg;
            assign busy[gi] = busy_reg;
         end
      end
   endgenerate

   genvar gk;
   generate
      for (gk = 0; gk < NRD; gk++) begin : g_read
         logic [ABITS-1:0] addr;
         logic [WIDTH-1:0] data;
         logic             bsy;

         assign addr = rd_addr[gk*ABITS +: ABITS];

         always_comb begin
            data = mem[addr];
            bsy  = busy[addr];
            if (BYPASS) begin
               for (int j = 0; j < NWR; j++) begin
                  if (wr_en[j] && wr_addr[j*ABITS +: ABITS] == addr) begin
                     data = wr_data[j*WIDTH +: WIDTH];
                     bsy  = 1'b0;
                  end
               end
            end
            if (ZERO_REG && addr == '0) begin
               data = '0;
               bsy  = 1'b0;
            end
            // Forwarded write data must not leak out while held in reset.
            if (!nrst) begin
               data = '0;
               bsy  = 1'b0;
            end
         end

         assign rd_data[gk*WIDTH +: WIDTH] = data;
         assign rd_busy[gk]                = bsy;
      end
   endgenerate

endmodule
